dac_ramp_sequencer: RTL and testbench

DAC_RAMP_SEQUENCER -- requirements
Module: dac_ramp_sequencer

---
 rtl/dac_seq_pkg.sv | 27 ++
 rtl/step_tick_gen.sv | 26 ++
 rtl/dac_ramp_sequencer.sv | 171 +++++++++++++++++
 tb/tb_dac_ramp_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_seq_pkg.sv
// rtl/dac_seq_pkg.sv - phase encoding, sizing constants and table helpers for the DAC ramp sequencer
package dac_seq_pkg;

    localparam int MAX_STEPS_DEF = 10;
    localparam int CODE_W_DEF    = 8;
    localparam int ENTRY_W       = 8;
    localparam int IDX_W         = 4;
    localparam int DWELL_W       = 16;
    // Widest table a 4-bit index can address; narrower tables are zero-extended to this.
    localparam int TBL_MAX_W     = ENTRY_W * (1 << IDX_W);

    localparam logic [1:0] PH_IDLE = 2'b00;
    localparam logic [1:0] PH_UP   = 2'b01;
    localparam logic [1:0] PH_DOWN = 2'b10;

    function automatic logic [ENTRY_W-1:0] tbl_slice(input logic [TBL_MAX_W-1:0] tbl,
                                                     input logic [IDX_W-1:0]     k);
        logic [TBL_MAX_W-1:0] shifted;
        shifted = tbl >> {k, 3'b000};
        return shifted[ENTRY_W-1:0];
    endfunction

    function automatic logic [IDX_W-1:0] clamp_count(input logic [7:0] n, input int max_steps);
        return (int'(n) > max_steps) ? IDX_W'(max_steps) : n[IDX_W-1:0];
    endfunction

endpackage

// File: rtl/step_tick_gen.sv
// rtl/step_tick_gen.sv - dwell prescaler: pulses tick once every dwell+1 cycles while not cleared
module step_tick_gen
    import dac_seq_pkg::*;
(
    input  logic               sclk,
    input  logic               rst,
    input  logic               clear,
    input  logic [DWELL_W-1:0] dwell,
    output logic               tick
);

    logic [DWELL_W-1:0] cnt;

    assign tick = (cnt == dwell);

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dac_ramp_sequencer.sv
// rtl/dac_ramp_sequencer.sv - table-driven up/down DAC ramp with per-period snapshot, dwell and abort
module dac_ramp_sequencer
    import dac_seq_pkg::*;
#(
    parameter int MAX_STEPS = MAX_STEPS_DEF,
    parameter int CODE_W    = CODE_W_DEF
) (
    input  logic                           sclk,
    input  logic                           rst,
    input  logic [ENTRY_W*MAX_STEPS-1:0]   up_tbl,
    input  logic [ENTRY_W*MAX_STEPS-1:0]   down_tbl,
    input  logic [7:0]                     up_states,
    input  logic [7:0]                     down_states,
    input  logic [CODE_W-1:0]              idle_code,
    input  logic [7:0]                     divider,
    input  logic [7:0]                     divider2,
    input  logic                           enable,
    input  logic                           reconfig,
    output logic [CODE_W-1:0]              dac_code,
    output logic                           dac_wr,
    output logic [1:0]                     phase,
    output logic [IDX_W-1:0]               step_idx,
    output logic                           period_done,
    output logic                           cfg_err
);

    localparam int TBL_W = ENTRY_W * MAX_STEPS;

    logic [TBL_W-1:0]   up_s, dn_s;
    logic [IDX_W-1:0]   nu_s, nd_s;
    logic [DWELL_W-1:0] dwell_s;
    logic               armed;

    logic [IDX_W-1:0]   nu_in, nd_in, idx_inc;
    logic               start_ok, running, tick;
    logic [1:0]         start_phase;
    logic [CODE_W-1:0]  start_code, up_next_code, dn_next_code, dn_first_code;

    logic [1:0]         ph_n;
    logic [IDX_W-1:0]   idx_n;
    logic [CODE_W-1:0]  code_n;
    logic               wr_n, pd_n, err_n, armed_n;
    logic               try_start, go_idle;

    assign nu_in    = clamp_count(up_states, MAX_STEPS);
    assign nd_in    = clamp_count(down_states, MAX_STEPS);
    assign start_ok = (nu_in != '0) || (nd_in != '0);
    assign running  = (phase == PH_UP) || (phase == PH_DOWN);
    assign idx_inc  = step_idx + 1'b1;

    assign start_phase   = (nu_in != '0) ? PH_UP : PH_DOWN;
    assign start_code    = (nu_in != '0) ? CODE_W'(up_tbl[ENTRY_W-1:0])
                                         : CODE_W'(down_tbl[ENTRY_W-1:0]);
    assign up_next_code  = CODE_W'(tbl_slice(TBL_MAX_W'(up_s), idx_inc));
    assign dn_next_code  = CODE_W'(tbl_slice(TBL_MAX_W'(dn_s), idx_inc));
    assign dn_first_code = CODE_W'(dn_s[ENTRY_W-1:0]);

    // Counter is held at zero whenever no period is running, so every period's first step gets a full dwell.
    step_tick_gen u_step_tick_gen (
        .sclk  (sclk),
        .rst   (rst),
        .clear (!running),
        .dwell (dwell_s),
        .tick  (tick)
    );

    always_comb begin
        ph_n      = phase;
        idx_n     = step_idx;
        code_n    = dac_code;
        wr_n      = 1'b0;
        pd_n      = 1'b0;
        err_n     = cfg_err;
        armed_n   = armed;
        try_start = 1'b0;
        go_idle   = 1'b0;

        case (phase)
            PH_IDLE: begin
                // The first idle cycle after reset always writes, even if idle_code happens to equal 0.
                code_n  = idle_code;
                wr_n    = (idle_code != dac_code) || !armed;
                armed_n = 1'b1;
                if (armed) begin
                    if (!enable) begin
                        err_n = 1'b0;
                    end else if (!start_ok) begin
                        err_n = 1'b1;
                    end else if (!reconfig) begin
                        try_start = 1'b1;
                    end
                end
            end
            PH_UP, PH_DOWN: begin
                if (reconfig) begin
                    go_idle = 1'b1;
                end else if (tick) begin
                    if (phase == PH_UP && step_idx != nu_s - 1'b1) begin
                        idx_n  = idx_inc;
                        code_n = up_next_code;
                        wr_n   = 1'b1;
                    end else if (phase == PH_UP && nd_s != '0) begin
                        ph_n   = PH_DOWN;
                        idx_n  = '0;
                        code_n = dn_first_code;
                        wr_n   = 1'b1;
                    end else if (phase == PH_DOWN && step_idx != nd_s - 1'b1) begin
                        idx_n  = idx_inc;
                        code_n = dn_next_code;
                        wr_n   = 1'b1;
                    end else begin
                        pd_n = 1'b1;
                        if (enable && start_ok) begin
                            try_start = 1'b1;
                        end else begin
                            go_idle = 1'b1;
                        end
                    end
                end
            end
            default: go_idle = 1'b1;
        endcase

        if (try_start) begin
            ph_n   = start_phase;
            idx_n  = '0;
            code_n = start_code;
            wr_n   = 1'b1;
            err_n  = 1'b0;
        end
        if (go_idle) begin
            ph_n   = PH_IDLE;
            idx_n  = '0;
            code_n = idle_code;
            wr_n   = 1'b1;
        end
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            phase       <= PH_IDLE;
            step_idx    <= '0;
            dac_code    <= '0;
            dac_wr      <= 1'b0;
            period_done <= 1'b0;
            cfg_err     <= 1'b0;
            armed       <= 1'b0;
            up_s        <= '0;
            dn_s        <= '0;
            nu_s        <= '0;
            nd_s        <= '0;
            dwell_s     <= '0;
        end else begin
            phase       <= ph_n;
            step_idx    <= idx_n;
            dac_code    <= code_n;
            dac_wr      <= wr_n;
            period_done <= pd_n;
            cfg_err     <= err_n;
            armed       <= armed_n;
            if (try_start) begin
                up_s    <= up_tbl;
                dn_s    <= down_tbl;
                nu_s    <= nu_in;
                nd_s    <= nd_in;
                dwell_s <= {divider2, divider};
            end
        end
    end

endmodule

// File: tb/tb_dac_ramp_sequencer.sv
// tb/tb_dac_ramp_sequencer.sv - randomized bench comparing the sequencer against a per-period code-list model
module tb_dac_ramp_sequencer;

    localparam int N = 10;

    logic         sclk = 1'b0;
    logic         rst = 1'b1;
    logic [79:0]  up_tbl, down_tbl;
    logic [7:0]   up_states, down_states, idle_code, divider, divider2;
    logic         enable, reconfig;
    logic [7:0]   dac_code;
    logic         dac_wr, period_done, cfg_err;
    logic [1:0]   phase;
    logic [3:0]   step_idx;

    dac_ramp_sequencer dut (
        .sclk        (sclk),
        .rst         (rst),
        .up_tbl      (up_tbl),
        .down_tbl    (down_tbl),
        .up_states   (up_states),
        .down_states (down_states),
        .idle_code   (idle_code),
        .divider     (divider),
        .divider2    (divider2),
        .enable      (enable),
        .reconfig    (reconfig),
        .dac_code    (dac_code),
        .dac_wr      (dac_wr),
        .phase       (phase),
        .step_idx    (step_idx),
        .period_done (period_done),
        .cfg_err     (cfg_err)
    );

    always #5 sclk = ~sclk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model: each started period is expanded into the full per-cycle list of (code, phase, idx, first-of-step).
    typedef struct {
        int code;
        int ph;
        int idx;
        bit first;
    } ent_t;

    ent_t q[$];
    int   m_code, m_ph, m_idx;
    bit   m_wr, m_pd, m_err, m_fresh, m_run;

    function automatic int entry(input logic [79:0] t, input int k);
        return int'(t[8*k +: 8]);
    endfunction

    function automatic int eff(input logic [7:0] n);
        return (int'(n) > N) ? N : int'(n);
    endfunction

    task automatic show_idle(input bit wr);
        m_code = int'(idle_code);
        m_ph   = 0;
        m_idx  = 0;
        m_wr   = wr;
    endtask

    task automatic show_front();
        m_code = q[0].code;
        m_ph   = q[0].ph;
        m_idx  = q[0].idx;
        m_wr   = q[0].first;
    endtask

    task automatic try_start(output bit ok);
        int nu, nd, d;
        nu = eff(up_states);
        nd = eff(down_states);
        d  = int'({divider2, divider});
        ok = 1'b0;
        if (nu + nd > 0) begin
            for (int k = 0; k < nu; k++)
                for (int r = 0; r <= d; r++) q.push_back('{entry(up_tbl, k), 1, k, r == 0});
            for (int k = 0; k < nd; k++)
                for (int r = 0; r <= d; r++) q.push_back('{entry(down_tbl, k), 2, k, r == 0});
            m_run = 1'b1;
            m_err = 1'b0;
            show_front();
            ok = 1'b1;
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_code = 0; m_ph = 0; m_idx = 0;
        m_wr = 0; m_pd = 0; m_err = 0; m_fresh = 0; m_run = 0;
    endtask

    task automatic model_step();
        bit ok;
        ok   = 1'b0;
        m_wr = 1'b0;
        m_pd = 1'b0;
        if (!m_fresh) begin
            m_fresh = 1'b1;
            show_idle(1'b1);
        end else if (m_run) begin
            if (reconfig) begin
                m_run = 1'b0;
                q.delete();
                show_idle(1'b1);
            end else begin
                void'(q.pop_front());
                if (q.size() > 0) begin
                    show_front();
                end else begin
                    m_pd = 1'b1;
                    if (enable) try_start(ok);
                    if (!ok) begin
                        m_run = 1'b0;
                        show_idle(1'b1);
                    end
                end
            end
        end else begin
            if (!enable) m_err = 1'b0;
            else if (eff(up_states) + eff(down_states) == 0) m_err = 1'b1;
            else if (!reconfig) try_start(ok);
            if (!ok) show_idle(m_code != int'(idle_code));
        end
    endtask

    task automatic compare();
        check("dac_code", dac_code, m_code);
        check("dac_wr", dac_wr, m_wr);
        check("phase", phase, m_ph);
        check("step_idx", step_idx, m_idx);
        check("period_done", period_done, m_pd);
        check("cfg_err", cfg_err, m_err);
    endtask

    task automatic cycle();
        @(posedge sclk);
        if (rst) model_reset();
        else model_step();
        @(negedge sclk);
        compare();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic wait_for(input int ph, input int idx, input int limit, input string tag);
        int k;
        k = 0;
        while (!(m_ph == ph && m_idx == idx) && k < limit) begin
            cycle();
            k++;
        end
        check(tag, phase * 16 + step_idx, ph * 16 + idx);
    endtask

    task automatic default_tables();
        int ups[10];
        ups = '{115, 118, 121, 124, 127, 128, 131, 134, 137, 140};
        for (int k = 0; k < N; k++) begin
            up_tbl[8*k +: 8]   = 8'(ups[k]);
            down_tbl[8*k +: 8] = 8'(ups[N-1-k]);
        end
    endtask

    task automatic random_tables();
        for (int k = 0; k < N; k++) begin
            up_tbl[8*k +: 8]   = 8'($urandom_range(0, 255));
            down_tbl[8*k +: 8] = 8'($urandom_range(0, 255));
        end
    endtask

    initial begin
        model_reset();
        default_tables();
        up_states = 8'd10; down_states = 8'd10;
        idle_code = 8'd128; divider = 8'd0; divider2 = 8'd0;
        enable = 1'b0; reconfig = 1'b0;

        cycle();
        rst = 1'b0;
        run(3);

        // Full ramp, one step per cycle.
        enable = 1'b1;
        run(45);
        enable = 1'b0;
        run(25);

        // Dwell 0x0102: a single period, enable dropped right after the start.
        divider2 = 8'd1; divider = 8'd2;
        enable = 1'b1;
        cycle();
        enable = 1'b0;
        run(20 * 259 + 5);
        divider2 = 8'd0; divider = 8'd0;

        // Clamp to MAX_STEPS with DOWN skipped.
        up_states = 8'd15; down_states = 8'd0;
        enable = 1'b1;
        run(25);
        enable = 1'b0;
        run(12);

        // Zero counts refused with cfg_err.
        up_states = 8'd0;
        enable = 1'b1;
        run(6);
        check("cfg_err_set", cfg_err, 1);
        check("cfg_err_phase", phase, 0);
        enable = 1'b0;
        cycle();
        check("cfg_err_clear", cfg_err, 0);

        // UP skipped.
        down_states = 8'd4;
        enable = 1'b1;
        run(10);
        enable = 1'b0;
        run(6);

        // Abort during UP idx 4.
        up_states = 8'd10; down_states = 8'd10;
        enable = 1'b1;
        wait_for(1, 4, 40, "wait_up4");
        reconfig = 1'b1;
        cycle();
        check("abort_phase", phase, 0);
        check("abort_code", dac_code, idle_code);
        check("abort_wr", dac_wr, 1);
        check("abort_pd", period_done, 0);
        run(3);
        reconfig = 1'b0;
        run(3);

        // Snapshot: table change mid-period, then enable dropped at DOWN idx 2.
        wait_for(1, 3, 40, "wait_up3");
        random_tables();
        run(25);
        wait_for(2, 2, 40, "wait_down2");
        enable = 1'b0;
        run(20);

        // Async reset mid-DOWN.
        default_tables();
        enable = 1'b1;
        wait_for(2, 3, 60, "wait_down3");
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("rst_code", dac_code, 0);
        check("rst_wr", dac_wr, 0);
        check("rst_phase", phase, 0);
        check("rst_idx", step_idx, 0);
        check("rst_pd", period_done, 0);
        @(negedge sclk);
        compare();
        enable = 1'b0;
        idle_code = 8'd0;
        rst = 1'b0;
        cycle();
        check("rst_rel_code", dac_code, 0);
        check("rst_rel_wr", dac_wr, 1);
        run(3);

        // Randomized configurations and control activity.
        for (int t = 0; t < 40; t++) begin
            random_tables();
            up_states   = 8'($urandom_range(0, 12));
            down_states = 8'($urandom_range(0, 12));
            divider     = 8'($urandom_range(0, 3));
            divider2    = 8'd0;
            for (int c = 0; c < 60; c++) begin
                enable   = ($urandom_range(0, 9) != 0);
                reconfig = ($urandom_range(0, 39) == 0);
                if ($urandom_range(0, 9) == 0) idle_code = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 29) == 0) random_tables();
                cycle();
            end
        end
        enable = 1'b0;
        reconfig = 1'b0;
        run(80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
